// File: rtl/apb_timer_rsp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_timer_rsp_pkg
// Purpose  : Shared definitions for the APB timer responder: register offsets,
//            CTRL field positions, the CTRL register struct, the APB wait-state
//            FSM encoding and a CTRL-to-bus-word helper.
// Ports    : none (package)
// Macros   : none
// Revision : 1.0 - initial release
// ============================================================================
package apb_timer_rsp_pkg;

    // Register offsets as decoded from paddr[3:2]
    localparam logic [1:0] c_reg_ctrl   = 2'd0;
    localparam logic [1:0] c_reg_cnt    = 2'd1;
    localparam logic [1:0] c_reg_cmp    = 2'd2;
    localparam logic [1:0] c_reg_status = 2'd3;

    // CTRL field positions within the 32-bit bus word
    localparam int c_ctrl_en_bit      = 0;
    localparam int c_ctrl_oneshot_bit = 1;
    localparam int c_ctrl_irq_en_bit  = 2;
    localparam int c_ctrl_presc_lsb   = 8;
    localparam int c_ctrl_presc_msb   = 15;

    // STATUS field position
    localparam int c_status_match_bit = 0;

    typedef struct packed {
        logic [7:0] presc;
        logic       irq_en;
        logic       oneshot;
        logic       en;
    } ctrl_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    // Place the CTRL fields at their bus positions; unused bits read 0.
    function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
        logic [31:0] w;
        w                                     = '0;
        w[c_ctrl_en_bit]                      = c.en;
        w[c_ctrl_oneshot_bit]                 = c.oneshot;
        w[c_ctrl_irq_en_bit]                  = c.irq_en;
        w[c_ctrl_presc_msb:c_ctrl_presc_lsb]  = c.presc;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_timer_rsp_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_timer_rsp_if
// Purpose  : APB3 bus bundle between a requester (master) and the timer
//            responder (slave).
// Ports    : psel, penable, pwrite, paddr[ADDR_WIDTH-1:0], pwdata[31:0]
//            (master -> slave); prdata[31:0], pready, pslverr (slave -> master)
// Macros   : none
// Revision : 1.0 - initial release
// ============================================================================
interface apb_timer_rsp_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [31:0]           pwdata;
    logic [31:0]           prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface
`default_nettype wire

// File: rtl/apb_timer_rsp_cntr.sv
`default_nettype none
// ============================================================================
// Module   : apb_timer_rsp_cntr
// Purpose  : Prescaler, 32-bit counter, compare register and match detection
//            for the APB timer responder.
// Ports    : clk, reset_n       - clock, asynchronous active-low reset
//            en_i, oneshot_i    - CTRL.EN / CTRL.ONESHOT
//            presc_i[7:0]       - CTRL.PRESC
//            ctrl_we_i          - CTRL write strobe (restarts the prescaler)
//            cnt_we_i, cmp_we_i - CNT / CMP write strobes
//            wdata_i[31:0]      - write data
//            cnt_o, cmp_o       - current CNT / CMP register values
//            match_set_o        - tick with CNT == CMP this cycle
//            en_clr_o           - one-shot match: clear CTRL.EN
// Macros   : none
// Revision : 1.0 - initial release
// ============================================================================
module apb_timer_rsp_cntr (
    input  wire         clk,
    input  wire         reset_n,
    input  wire         en_i,
    input  wire         oneshot_i,
    input  wire  [7:0]  presc_i,
    input  wire         ctrl_we_i,
    input  wire         cnt_we_i,
    input  wire         cmp_we_i,
    input  wire  [31:0] wdata_i,
    output logic [31:0] cnt_o,
    output logic [31:0] cmp_o,
    output logic        match_set_o,
    output logic        en_clr_o
);

    logic [7:0]  pcnt_q, pcnt_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] cmp_q, cmp_d;
    logic        tick;
    logic        hit;

    assign tick = en_i && (pcnt_q == presc_i);
    assign hit  = tick && (cnt_q == cmp_q);

    always_comb begin
        pcnt_d = pcnt_q;
        if (en_i) begin
            pcnt_d = tick ? 8'd0 : pcnt_q + 8'd1;
        end
        // Any CTRL write restarts the prescale period from zero.
        if (ctrl_we_i) begin
            pcnt_d = 8'd0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (hit) begin
            cnt_d = 32'd0;
        end else if (tick) begin
            cnt_d = cnt_q + 32'd1;
        end
        // A bus write to CNT overrides whatever the tick would have done.
        if (cnt_we_i) begin
            cnt_d = wdata_i;
        end
    end

    assign cmp_d = cmp_we_i ? wdata_i : cmp_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt_q <= 8'd0;
            cnt_q  <= 32'd0;
            cmp_q  <= 32'd0;
        end else begin
            pcnt_q <= pcnt_d;
            cnt_q  <= cnt_d;
            cmp_q  <= cmp_d;
        end
    end

    assign cnt_o       = cnt_q;
    assign cmp_o       = cmp_q;
    assign match_set_o = hit;
    assign en_clr_o    = hit && oneshot_i;

endmodule
`default_nettype wire

// File: rtl/apb_timer_rsp.sv
`default_nettype none
// ============================================================================
// Module   : apb_timer_rsp
// Purpose  : APB3 completer implementing a 32-bit prescaled timer with compare
//            match and a level interrupt. Holds the wait-state FSM, the CTRL
//            and STATUS registers, the readback mux and the irq flop.
// Ports    : clk      - clock, all logic on the rising edge
//            reset_n  - asynchronous active-low reset
//            apb      - APB3 slave modport (psel, penable, pwrite, paddr,
//                       pwdata, prdata, pready, pslverr)
//            irq      - registered level interrupt (MATCH & IRQ_EN)
// Params   : ADDR_WIDTH  - paddr width, only [3:2] decode the register map
//            WAIT_STATES - access cycles with pready low before completion
// Macros   : APB_TIMER_RSP_PSLVERR_EN - when defined, any access with a
//            nonzero paddr[ADDR_WIDTH-1:4] completes with pslverr, writes are
//            dropped and reads return 0; otherwise upper bits alias.
// Revision : 1.0 - initial release
// ============================================================================
module apb_timer_rsp
    import apb_timer_rsp_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 0
) (
    input  wire            clk,
    input  wire            reset_n,
    apb_timer_rsp_if.slave apb,
    output logic           irq
);

    localparam logic [2:0] c_wait_last = 3'(WAIT_STATES);

    apb_state_e  state_q;
    logic [2:0]  wcnt_q;

    ctrl_t       ctrl_q, ctrl_d;
    logic        match_q, match_d;

    logic        pready;
    logic        xfer_done;
    logic        addr_err;
    logic [1:0]  reg_sel;
    logic        wr_ok;
    logic        ctrl_we, cnt_we, cmp_we, status_we;
    logic [31:0] cnt_val, cmp_val;
    logic        match_set, en_clr;
    logic [31:0] rdata;
    logic        unused_addr_bits;

    // ------------------------------------------------------------------------
    // Wait-state FSM. The counter runs only in ACCESS; pready is decoded from
    // state and counter so it is high for exactly the last ACCESS cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            wcnt_q  <= 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    wcnt_q <= 3'd0;
                    if (apb.psel && !apb.penable) begin
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    wcnt_q  <= 3'd0;
                    state_q <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (!apb.psel || (wcnt_q == c_wait_last)) begin
                        state_q <= ST_IDLE;
                        wcnt_q  <= 3'd0;
                    end else begin
                        wcnt_q  <= wcnt_q + 3'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    wcnt_q  <= 3'd0;
                end
            endcase
        end
    end

    assign pready    = (state_q == ST_ACCESS) && (wcnt_q == c_wait_last);
    assign xfer_done = apb.psel && apb.penable && pready;
    assign reg_sel   = apb.paddr[3:2];

`ifdef APB_TIMER_RSP_PSLVERR_EN
    assign addr_err = |apb.paddr[ADDR_WIDTH-1:4];
`else
    assign addr_err = 1'b0;
`endif

    // Byte-lane bits never decode; upper bits decode only with pslverr enabled.
    assign unused_addr_bits = ^{apb.paddr[ADDR_WIDTH-1:4], apb.paddr[1:0]};

    assign wr_ok     = xfer_done && apb.pwrite && !addr_err;
    assign ctrl_we   = wr_ok && (reg_sel == c_reg_ctrl);
    assign cnt_we    = wr_ok && (reg_sel == c_reg_cnt);
    assign cmp_we    = wr_ok && (reg_sel == c_reg_cmp);
    assign status_we = wr_ok && (reg_sel == c_reg_status);

    // ------------------------------------------------------------------------
    // Timer core
    // ------------------------------------------------------------------------
    apb_timer_rsp_cntr u_cntr (
        .clk         (clk),
        .reset_n     (reset_n),
        .en_i        (ctrl_q.en),
        .oneshot_i   (ctrl_q.oneshot),
        .presc_i     (ctrl_q.presc),
        .ctrl_we_i   (ctrl_we),
        .cnt_we_i    (cnt_we),
        .cmp_we_i    (cmp_we),
        .wdata_i     (apb.pwdata),
        .cnt_o       (cnt_val),
        .cmp_o       (cmp_val),
        .match_set_o (match_set),
        .en_clr_o    (en_clr)
    );

    // ------------------------------------------------------------------------
    // CTRL / STATUS next state
    // ------------------------------------------------------------------------
    always_comb begin
        ctrl_d = ctrl_q;
        if (ctrl_we) begin
            ctrl_d.en      = apb.pwdata[c_ctrl_en_bit];
            ctrl_d.oneshot = apb.pwdata[c_ctrl_oneshot_bit];
            ctrl_d.irq_en  = apb.pwdata[c_ctrl_irq_en_bit];
            ctrl_d.presc   = apb.pwdata[c_ctrl_presc_msb:c_ctrl_presc_lsb];
        end
        // A one-shot match always stops the timer, even over a same-cycle
        // CTRL write.
        if (en_clr) begin
            ctrl_d.en = 1'b0;
        end
    end

    always_comb begin
        match_d = match_q;
        if (status_we && apb.pwdata[c_status_match_bit]) begin
            match_d = 1'b0;
        end
        // A new match beats a simultaneous write-1-to-clear.
        if (match_set) begin
            match_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q  <= '0;
            match_q <= 1'b0;
            irq     <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            match_q <= match_d;
            irq     <= match_q && ctrl_q.irq_en;
        end
    end

    // ------------------------------------------------------------------------
    // Readback: current register contents, only during the completion cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        rdata = 32'd0;
        if (xfer_done && !addr_err) begin
            case (reg_sel)
                c_reg_ctrl:   rdata = ctrl_to_word(ctrl_q);
                c_reg_cnt:    rdata = cnt_val;
                c_reg_cmp:    rdata = cmp_val;
                c_reg_status: rdata = {31'd0, match_q};
                default:      rdata = 32'd0;
            endcase
        end
    end

    assign apb.prdata  = rdata;
    assign apb.pready  = pready;
    assign apb.pslverr = pready && addr_err;

endmodule
`default_nettype wire

// File: tb/tb_apb_timer_rsp.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_timer_rsp
// Purpose  : Directed self-checking bench for apb_timer_rsp (WAIT_STATES=2).
//            Expected values are hand-derived from the transfer timing: each
//            transfer spans 6 clock edges from its first edge to completion.
// Macros   : APB_TIMER_RSP_PSLVERR_EN selects the address-error expectations.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_apb_timer_rsp;

    localparam int c_ws      = 2;
    localparam int c_timeout = 32;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic irq;

    int n_checks = 0;
    int n_fail   = 0;

    apb_timer_rsp_if #(.ADDR_WIDTH(12)) bus ();

    apb_timer_rsp #(
        .ADDR_WIDTH  (12),
        .WAIT_STATES (c_ws)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .apb     (bus),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    // One full APB transfer. nwait counts penable cycles with pready low.
    // Returns one ns after the completion edge with the bus idle again.
    task automatic apb_xfer(input logic wr, input logic [11:0] addr,
                            input logic [31:0] wd, output logic [31:0] rdata,
                            output logic slverr, output int nwait);
        @(posedge clk); #1;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = wr;
        bus.paddr   = addr;
        bus.pwdata  = wd;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        nwait = 0;
        while (bus.pready !== 1'b1 && nwait < c_timeout) begin
            @(posedge clk); #1;
            nwait++;
        end
        rdata  = bus.prdata;
        slverr = bus.pslverr;
        n_checks++;
        if (nwait >= c_timeout) begin
            n_fail++;
            $display("FAIL apb_timeout addr=0x%03h: waited %0d cycles, required < %0d", addr, nwait, c_timeout);
        end
        @(posedge clk); #1;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] wd);
        logic [31:0] rd;
        logic        err;
        int          nw;
        apb_xfer(1'b1, addr, wd, rd, err, nw);
    endtask

    task automatic rd_reg(input logic [11:0] addr, output logic [31:0] rd, output logic err);
        int nw;
        apb_xfer(1'b0, addr, 32'd0, rd, err, nw);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic        err;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = '0;  bus.pwdata = '0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.pready !== 1'b0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: pready=%b irq=%b, required 0 0", bus.pready, irq);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_reg(12'(i * 4), rd, err);
            n_checks++;
            if (rd !== 32'd0 || err !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_read reg%0d: data=0x%08h err=%b, required 0x00000000 0", i, rd, err);
            end
        end
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_irq: irq=%b, required 0", irq);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd;
        logic        err;
        int          nw;
        apb_xfer(1'b1, 12'h008, 32'h5, rd, err, nw);
        // One SETUP-state cycle, then c_ws ACCESS cycles with pready low.
        n_checks++;
        if (nw !== c_ws + 1) begin
            n_fail++;
            $display("FAIL wait_states: low cycles=%0d, required %0d", nw, c_ws + 1);
        end
        n_checks++;
        if (bus.pready !== 1'b0) begin
            n_fail++;
            $display("FAIL pready_one_cycle: pready=%b after completion, required 0", bus.pready);
        end
        rd_reg(12'h008, rd, err);
        n_checks++;
        if (rd !== 32'h5 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL cmp_readback: data=0x%08h err=%b, required 0x00000005 0", rd, err);
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] rd;
        logic        err;
        wr(12'h004, 32'h0);
        wr(12'h008, 32'h0);
        wr(12'h00C, 32'h1);
        wr(12'h000, 32'h3);            // EN | ONESHOT, PRESC=0
        rd_reg(12'h000, rd, err);
        n_checks++;
        if (rd !== 32'h2) begin
            n_fail++;
            $display("FAIL oneshot_en_clr: ctrl=0x%08h, required 0x00000002", rd);
        end
        rd_reg(12'h004, rd, err);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL oneshot_cnt: cnt=0x%08h, required 0x00000000", rd);
        end
        rd_reg(12'h00C, rd, err);
        n_checks++;
        if (rd !== 32'h1) begin
            n_fail++;
            $display("FAIL oneshot_match: status=0x%08h, required 0x00000001", rd);
        end
        wr(12'h00C, 32'h1);
        rd_reg(12'h00C, rd, err);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL oneshot_w1c: status=0x%08h, required 0x00000000", rd);
        end
    endtask

    // CTRL write completes at edge C. Ticks land on C+4, C+8, C+12 (match),
    // C+16, ... ; irq follows MATCH one edge later (C+13).
    task automatic test_periodic();
        logic [31:0] rd;
        logic        err;
        int          first_hi;
        wr(12'h008, 32'h2);
        wr(12'h000, 32'h0000_0305);
        rd_reg(12'h004, rd, err);      // sampled after C+5
        n_checks++;
        if (rd !== 32'h1) begin
            n_fail++;
            $display("FAIL periodic_cnt_first: cnt=0x%08h, required 0x00000001", rd);
        end
        first_hi = -1;
        for (int i = 7; i <= 16; i++) begin
            @(posedge clk); #1;
            if (irq === 1'b1 && first_hi < 0) first_hi = i;
        end
        n_checks++;
        if (first_hi !== 13) begin
            n_fail++;
            $display("FAIL periodic_irq_edge: irq rose after edge C+%0d, required C+13", first_hi);
        end
        rd_reg(12'h004, rd, err);      // sampled after C+21
        n_checks++;
        if (rd !== 32'h2) begin
            n_fail++;
            $display("FAIL periodic_cnt_restart: cnt=0x%08h, required 0x00000002", rd);
        end
        rd_reg(12'h00C, rd, err);
        n_checks++;
        if (rd !== 32'h1) begin
            n_fail++;
            $display("FAIL periodic_match: status=0x%08h, required 0x00000001", rd);
        end
        wr(12'h000, 32'h0000_0304);    // stop at C+34, CNT frozen at 2
        rd_reg(12'h004, rd, err);
        n_checks++;
        if (rd !== 32'h2 || irq !== 1'b1) begin
            n_fail++;
            $display("FAIL periodic_freeze: cnt=0x%08h irq=%b, required 0x00000002 1", rd, irq);
        end
    endtask

    // CMP=0, CNT=0, PRESC=0: every cycle is a match, so every W1C collides
    // with a set and irq must never drop while running.
    task automatic test_w1c_collision();
        logic [31:0] rd;
        logic        err;
        wr(12'h004, 32'h0);
        wr(12'h008, 32'h0);
        wr(12'h00C, 32'h1);
        wr(12'h000, 32'h5);
        wr(12'h00C, 32'h1);
        @(posedge clk); #1;
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL w1c_set_wins_irq: irq=%b, required 1", irq);
        end
        rd_reg(12'h00C, rd, err);
        n_checks++;
        if (rd !== 32'h1) begin
            n_fail++;
            $display("FAIL w1c_set_wins: status=0x%08h, required 0x00000001", rd);
        end
        wr(12'h000, 32'h4);            // stop, keep IRQ_EN
        wr(12'h00C, 32'h1);            // clears MATCH at completion edge W
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL w1c_irq_hold: irq=%b at W, required 1", irq);
        end
        @(posedge clk); #1;
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL w1c_irq_drop: irq=%b at W+1, required 0", irq);
        end
        rd_reg(12'h00C, rd, err);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL w1c_clear: status=0x%08h, required 0x00000000", rd);
        end
    endtask

    // CNT written while ticking every cycle: the write wins at W, then five
    // ticks (W+1..W+5) before the readback sample wrap past 2^32.
    task automatic test_cnt_write_wrap();
        logic [31:0] rd;
        logic        err;
        wr(12'h008, 32'h0000_1000);
        wr(12'h000, 32'h1);
        wr(12'h004, 32'hFFFF_FFFE);
        rd_reg(12'h004, rd, err);
        n_checks++;
        if (rd !== 32'h3) begin
            n_fail++;
            $display("FAIL cnt_write_wrap: cnt=0x%08h, required 0x00000003", rd);
        end
        wr(12'h000, 32'h0);
    endtask

    task automatic test_addr_alias();
        logic [31:0] rd;
        logic        err;
        int          nw;
        logic        exp_err;
        logic [31:0] exp_ctrl, exp_cmp;
`ifdef APB_TIMER_RSP_PSLVERR_EN
        exp_err  = 1'b1;
        exp_ctrl = 32'h0;
        exp_cmp  = 32'h0000_1000;
`else
        exp_err  = 1'b0;
        exp_ctrl = 32'h0000_0A02;
        exp_cmp  = 32'h0000_0077;
`endif
        apb_xfer(1'b1, 12'h010, 32'h0000_0A02, rd, err, nw);
        n_checks++;
        if (err !== exp_err) begin
            n_fail++;
            $display("FAIL alias_wr_err: pslverr=%b, required %b", err, exp_err);
        end
        rd_reg(12'h000, rd, err);
        n_checks++;
        if (rd !== exp_ctrl || err !== 1'b0) begin
            n_fail++;
            $display("FAIL alias_ctrl: ctrl=0x%08h err=%b, required 0x%08h 0", rd, err, exp_ctrl);
        end
        wr(12'h018, 32'h77);
        rd_reg(12'h008, rd, err);
        n_checks++;
        if (rd !== exp_cmp) begin
            n_fail++;
            $display("FAIL alias_cmp: cmp=0x%08h, required 0x%08h", rd, exp_cmp);
        end
        rd_reg(12'h01C, rd, err);
        n_checks++;
        if (rd !== 32'h0 || err !== exp_err) begin
            n_fail++;
            $display("FAIL alias_rd_err: data=0x%08h err=%b, required 0x00000000 %b", rd, err, exp_err);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        err;
        @(posedge clk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 12'h008; bus.pwdata = 32'h55;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        @(posedge clk); #1;            // first ACCESS cycle
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus.pready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_pready: pready=%b, required 0", bus.pready);
        end
        @(posedge clk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        reset_n = 1'b1;
        rd_reg(12'h008, rd, err);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_cmp: cmp=0x%08h, required 0x00000000", rd);
        end
        rd_reg(12'h000, rd, err);
        n_checks++;
        if (rd !== 32'h0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_ctrl: ctrl=0x%08h irq=%b, required 0x00000000 0", rd, irq);
        end
    endtask

    initial begin
        test_reset();
        test_wait_states();
        test_oneshot();
        test_periodic();
        test_w1c_collision();
        test_cnt_write_wrap();
        test_addr_alias();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
